// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO controller wrapped around an external
// simple dual-port RAM. Port A is the write port. Port B is a registered read
// port with one cycle of latency. A 2-entry output buffer is kept filled ahead
// of the consumer, which gives first-word-fall-through behaviour at one word
// per cycle.
//
// Optional feature: define SYNC_FIFO_LEVEL_EN to add the LEVEL output, which
// reports the total number of words held.
//
// Handshake: a beat transfers on a rising CLK edge where VALID and READY are
// both high. VALID does not wait for READY. Once VALID is raised, it and DATA
// stay stable until the transfer completes.
module sync_fifo_ctrl #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              S_VALID,
  output logic              S_READY,
  input  logic [DWIDTH-1:0] S_DATA,
  output logic              M_VALID,
  input  logic              M_READY,
  output logic [DWIDTH-1:0] M_DATA,
  output logic              RAM_ENA,
  output logic              RAM_WEA,
  output logic [AWIDTH-1:0] RAM_ADDRA,
  output logic [DWIDTH-1:0] RAM_DINA,
  output logic              RAM_ENB,
  output logic [AWIDTH-1:0] RAM_ADDRB,
  input  logic [DWIDTH-1:0] RAM_DOUTB
`ifdef SYNC_FIFO_LEVEL_EN
  ,
  output logic [AWIDTH+1:0] LEVEL
`endif
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH:0] FULL_CNT = (AWIDTH+1)'(DEPTH);

  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]   ram_cnt_q, ram_cnt_d;
  logic              rd_pend_q;
  logic [1:0]        out_cnt_q, out_cnt_d;
  logic [DWIDTH-1:0] buf0_q, buf0_d;  // head of the output buffer
  logic [DWIDTH-1:0] buf1_q, buf1_d;

  logic       push;
  logic       pop;
  logic       issue;
  logic [2:0] occ_after_pop;
  logic [1:0] fill_slot;

  // Compute the handshakes and drive the RAM ports straight from the current state.
  always_comb begin
    S_READY   = RST_N && (ram_cnt_q != FULL_CNT);
    push      = S_VALID && S_READY;
    M_VALID   = (out_cnt_q != 2'd0);
    pop       = M_VALID && M_READY;
    // Count buffer slots that are occupied or already claimed by a pending read.
    // A read is issued only when that count leaves room after this cycle's pop.
    occ_after_pop = {1'b0, out_cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};
    issue     = (ram_cnt_q != '0) && (occ_after_pop < 3'd2);
    RAM_ENA   = push;
    RAM_WEA   = push;
    RAM_ADDRA = wr_ptr_q;
    RAM_DINA  = S_DATA;
    RAM_ENB   = issue;
    RAM_ADDRB = rd_ptr_q;
    M_DATA    = buf0_q;
  end

  // Next-state logic for the pointers, the counters and the ordered output buffer.
  always_comb begin
    wr_ptr_d  = push  ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = issue ? rd_ptr_q + 1'b1 : rd_ptr_q;
    ram_cnt_d = ram_cnt_q + {{AWIDTH{1'b0}}, push} - {{AWIDTH{1'b0}}, issue};
    out_cnt_d = out_cnt_q + {1'b0, rd_pend_q} - {1'b0, pop};
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    // The head is shifted forward only when a second word is behind it.
    // Otherwise the head keeps its last value after it is consumed.
    if (pop && (out_cnt_q == 2'd2)) begin
      buf0_d = buf1_q;
    end
    // Returning read data goes behind whatever word is still buffered.
    fill_slot = out_cnt_q - {1'b0, pop};
    if (rd_pend_q) begin
      if (fill_slot == 2'd0) begin
        buf0_d = RAM_DOUTB;
      end else begin
        buf1_d = RAM_DOUTB;
      end
    end
  end

  // State registers. Reset is asynchronous, and it also discards any in-flight read.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ram_cnt_q <= '0;
      rd_pend_q <= 1'b0;
      out_cnt_q <= 2'd0;
      buf0_q    <= '0;
      buf1_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ram_cnt_q <= ram_cnt_d;
      rd_pend_q <= issue;
      out_cnt_q <= out_cnt_d;
      buf0_q    <= buf0_d;
      buf1_q    <= buf1_d;
    end
  end

`ifdef SYNC_FIFO_LEVEL_EN
  // Total occupancy: words in the RAM, plus a read in flight, plus buffered words.
  assign LEVEL = {1'b0, ram_cnt_q}
               + {{(AWIDTH+1){1'b0}}, rd_pend_q}
               + {{AWIDTH{1'b0}}, out_cnt_q};
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl: directed bench for sync_fifo_ctrl with DWIDTH=8 and
// AWIDTH=2, using a behavioural registered-read RAM model.
// The LEVEL checks are included only when SYNC_FIFO_LEVEL_EN is defined.
module tb_sync_fifo_ctrl;
  localparam int DW = 8;
  localparam int AW = 2;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          S_VALID;
  logic          S_READY;
  logic [DW-1:0] S_DATA;
  logic          M_VALID;
  logic          M_READY;
  logic [DW-1:0] M_DATA;
  logic          RAM_ENA, RAM_WEA, RAM_ENB;
  logic [AW-1:0] RAM_ADDRA, RAM_ADDRB;
  logic [DW-1:0] RAM_DINA, RAM_DOUTB;
`ifdef SYNC_FIFO_LEVEL_EN
  logic [AW+1:0] LEVEL;
`endif

  sync_fifo_ctrl #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .S_VALID(S_VALID), .S_READY(S_READY), .S_DATA(S_DATA),
    .M_VALID(M_VALID), .M_READY(M_READY), .M_DATA(M_DATA),
    .RAM_ENA(RAM_ENA), .RAM_WEA(RAM_WEA), .RAM_ADDRA(RAM_ADDRA), .RAM_DINA(RAM_DINA),
    .RAM_ENB(RAM_ENB), .RAM_ADDRB(RAM_ADDRB), .RAM_DOUTB(RAM_DOUTB)
`ifdef SYNC_FIFO_LEVEL_EN
    , .LEVEL(LEVEL)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  // Behavioural simple dual-port RAM with a registered read port.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  initial for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
  initial RAM_DOUTB = '0;
  always @(posedge CLK) begin
    if (RAM_ENA && RAM_WEA) mem[RAM_ADDRA] <= RAM_DINA;
    if (RAM_ENB) RAM_DOUTB <= mem[RAM_ADDRB];
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_wa, exp_ra;
  int n_checks = 0;
  int n_errors = 0;
  int cyc, n_push, n_pop, first_pop, last_pop;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  // Record this cycle's transfers, then advance to 1 time unit after the next rising edge.
  task automatic step();
    if (S_VALID && S_READY) begin
      check("wr_addr", {30'd0, RAM_ADDRA}, {30'd0, exp_wa});
      check("wr_en", {30'd0, RAM_ENA, RAM_WEA}, 32'd3);
      exp_q.push_back(S_DATA);
      exp_wa = exp_wa + 1'b1;
      n_push++;
    end
    if (RAM_ENB) begin
      check("rd_addr", {30'd0, RAM_ADDRB}, {30'd0, exp_ra});
      exp_ra = exp_ra + 1'b1;
    end
    if (M_VALID && M_READY) begin
      if (exp_q.size() == 0) check("pop_when_empty", {31'd0, M_VALID}, 32'd0);
      else check("pop_data", {24'd0, M_DATA}, {24'd0, exp_q.pop_front()});
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
      n_pop++;
    end
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic clear_model();
    exp_q.delete();
    exp_wa = '0;
    exp_ra = '0;
  endtask

  task automatic start_scenario();
    cyc = 0; n_push = 0; n_pop = 0; first_pop = -1; last_pop = -1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  // ---------------- driver / directed sequence ----------------
  initial begin
    int pb;
    RST_N = 1'b0; S_VALID = 1'b0; S_DATA = '0; M_READY = 1'b0;
    clear_model();
    start_scenario();

    // Reset: hold low for 3 cycles, then release.
    repeat (3) @(posedge CLK);
    #1;
    check("rst_s_ready_low", {31'd0, S_READY}, 32'd0);
    check("rst_m_valid_low", {31'd0, M_VALID}, 32'd0);
    RST_N = 1'b1;
    settle();
    check("rst_s_ready", {31'd0, S_READY}, 32'd1);
    check("rst_m_valid", {31'd0, M_VALID}, 32'd0);
    check("rst_m_data", {24'd0, M_DATA}, 32'd0);
    check("rst_ram_en", {30'd0, RAM_ENA, RAM_ENB}, 32'd0);
`ifdef SYNC_FIFO_LEVEL_EN
    check("rst_level", {28'd0, LEVEL}, 32'd0);
`endif

    // Single word 0xA5 with the consumer stalled.
    start_scenario();
    S_VALID = 1'b1; S_DATA = 8'hA5; M_READY = 1'b0;
    settle();
    check("single_addra", {30'd0, RAM_ADDRA}, 32'd0);
    step();
    S_VALID = 1'b0;
    settle();
    check("single_enb", {31'd0, RAM_ENB}, 32'd1);
    check("single_addrb", {30'd0, RAM_ADDRB}, 32'd0);
    step();
    settle();
    check("single_mvalid_c2", {31'd0, M_VALID}, 32'd0);
    step();
    settle();
    check("single_mvalid_c3", {31'd0, M_VALID}, 32'd1);
    check("single_mdata_c3", {24'd0, M_DATA}, 32'hA5);
    step();
    settle();
    check("single_mdata_held", {24'd0, M_DATA}, 32'hA5);
    M_READY = 1'b1;
    step();
    M_READY = 1'b0;
    settle();
    check("single_drained", {31'd0, M_VALID}, 32'd0);
    check("single_mdata_keep", {24'd0, M_DATA}, 32'hA5);

    // Fill: offer 0x01..0x08 with the consumer stalled.
    start_scenario();
    for (int i = 0; i < 10; i++) begin
      S_VALID = (n_push < 8);
      S_DATA  = 8'(n_push + 1);
      settle();
      check($sformatf("fill_s_ready_c%0d", i), {31'd0, S_READY}, (i < 6) ? 32'd1 : 32'd0);
      step();
    end
    S_VALID = 1'b0;
    settle();
    check("fill_accepted", n_push, 32'd6);
`ifdef SYNC_FIFO_LEVEL_EN
    check("fill_level", {28'd0, LEVEL}, 32'd6);
`endif
    M_READY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      settle();
      step();
    end
    settle();
    check("fill_drain_count", n_pop, 32'd6);
    check("fill_drain_empty", {31'd0, M_VALID}, 32'd0);

    // Streaming: 16 words on consecutive cycles.
    start_scenario();
    for (int i = 0; i < 22; i++) begin
      S_VALID = (i < 16);
      S_DATA  = 8'(8'h10 + i);
      M_READY = 1'b1;
      settle();
      step();
    end
    S_VALID = 1'b0;
    settle();
    check("stream_pushes", n_push, 32'd16);
    check("stream_pops", n_pop, 32'd16);
    check("stream_first_out", first_pop, 32'd3);
    check("stream_last_out", last_pop, 32'd18);

    // Backpressure: continuous input, consumer ready on alternate cycles.
    start_scenario();
    while (cyc < 200 && n_pop < 20) begin
      S_VALID = (n_push < 20);
      S_DATA  = 8'(8'h20 + n_push);
      M_READY = (cyc % 2 == 0);
      settle();
      step();
    end
    S_VALID = 1'b0; M_READY = 1'b0;
    settle();
    check("bp_pushes", n_push, 32'd20);
    check("bp_pops", n_pop, 32'd20);
    check("bp_empty", {31'd0, M_VALID}, 32'd0);

    // Reset mid-operation: 3 words stored with a read in flight.
    start_scenario();
    for (int i = 0; i < 3; i++) begin
      S_VALID = 1'b1;
      S_DATA  = 8'(8'h30 + i);
      settle();
      step();
    end
    S_VALID = 1'b0;
    settle();
    check("mid_pre_mvalid", {31'd0, M_VALID}, 32'd1);
    RST_N = 1'b0;
    settle();
    check("mid_mvalid_drop", {31'd0, M_VALID}, 32'd0);
    check("mid_s_ready_drop", {31'd0, S_READY}, 32'd0);
    check("mid_ram_en", {30'd0, RAM_ENA, RAM_ENB}, 32'd0);
    check("mid_addrs", {28'd0, RAM_ADDRA, RAM_ADDRB}, 32'd0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    clear_model();
    start_scenario();
    settle();
    check("mid_after_mvalid", {31'd0, M_VALID}, 32'd0);
    check("mid_after_s_ready", {31'd0, S_READY}, 32'd1);
`ifdef SYNC_FIFO_LEVEL_EN
    check("mid_after_level", {28'd0, LEVEL}, 32'd0);
`endif
    S_VALID = 1'b1; S_DATA = 8'h5A;
    settle();
    step();
    S_VALID = 1'b0;
    for (int i = 1; i < 3; i++) begin
      settle();
      check($sformatf("mid_mvalid_c%0d", i), {31'd0, M_VALID}, 32'd0);
      step();
    end
    settle();
    check("mid_mvalid_c3", {31'd0, M_VALID}, 32'd1);
    check("mid_first_word", {24'd0, M_DATA}, 32'h5A);
    pb = n_pop;
    M_READY = 1'b1;
    step();
    M_READY = 1'b0;
    settle();
    check("mid_single_pop", n_pop - pb, 32'd1);
    check("mid_final_empty", {31'd0, M_VALID}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/sync_fifo_ctrl.md
# sync_fifo_ctrl

Single-clock FIFO controller that drives an external simple dual-port RAM (port A write, port B registered read, 1-cycle read latency) and presents ready/valid streaming interfaces on both sides. Write-side control decides RAM writes. Read-side control prefetches from the RAM into a 2-entry output buffer, so the consumer sees first-word-fall-through data at full throughput despite the RAM's registered read. The block sits directly upstream of the RAM and wraps it into a complete FIFO.

## Interface
- DWIDTH, 32, data width; must match the RAM.
- AWIDTH, 5, RAM address width; RAM depth DEPTH = 2^AWIDTH.
- CLK  in  1  single clock; all logic is on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- S_VALID  in  1  producer has a word.
- S_READY  out  1  controller accepts a word.
- S_DATA  in  DWIDTH  producer word.
- M_VALID  out  1  output word available.
- M_READY  in  1  consumer takes the word.
- M_DATA  out  DWIDTH  head word.
- RAM_ENA  out  1  RAM port A enable.
- RAM_WEA  out  1  RAM port A write enable.
- RAM_ADDRA  out  AWIDTH  write address.
- RAM_DINA  out  DWIDTH  write data; equal to S_DATA.
- RAM_ENB  out  1  RAM port B read enable.
- RAM_ADDRB  out  AWIDTH  read address.
- RAM_DOUTB  in  DWIDTH  RAM read data, valid the cycle after RAM_ENB.
- LEVEL  out  AWIDTH+2  total words held; present only with SYNC_FIFO_LEVEL_EN.

## Operation
- State:
  - wr_ptr and rd_ptr, each AWIDTH bits, wrapping modulo DEPTH.
  - ram_cnt, 0..DEPTH.
  - rd_pend: a read was issued last cycle.
  - out_cnt, 0..2: the output buffer.
- Total capacity is DEPTH+2.
- push = S_VALID && S_READY. On push: RAM_ENA = RAM_WEA = 1, RAM_ADDRA = wr_ptr, then wr_ptr increments. Otherwise RAM_ENA = RAM_WEA = 0.
- S_READY = RST_N && (ram_cnt != DEPTH).
- pop = M_VALID && M_READY. M_VALID = (out_cnt != 0). M_DATA = oldest buffered word.
- Read issue: issue = (ram_cnt != 0) && (out_cnt + rd_pend - pop < 2).
  - On issue: RAM_ENB = 1, RAM_ADDRB = rd_ptr, then rd_ptr increments, and rd_pend is set next cycle. Otherwise RAM_ENB = 0.
- When rd_pend = 1, RAM_DOUTB is written into the output buffer behind any remaining word. Order is strictly preserved.
- Counter updates:
  - ram_cnt_next = ram_cnt + push - issue.
  - out_cnt_next = out_cnt + rd_pend - pop.
  - Simultaneous push and issue are legal.
- No address collision: a read only targets entries written at least one cycle earlier, and ram_cnt < DEPTH during a push guarantees wr_ptr != rd_ptr whenever both are active.
- Reset, including mid-operation, takes effect immediately and asynchronously:
  - pointers, counters and rd_pend go to 0;
  - M_VALID = 0, M_DATA = 0, S_READY = 0 while RST_N is low;
  - all RAM enables = 0, addresses = 0.
  - In-flight read data and stored words are discarded. RAM contents are not cleared.

## Timing
- Write to an empty FIFO, accepted in cycle 0:
  - read issued in cycle 1;
  - RAM_DOUTB valid in cycle 2;
  - M_VALID = 1 in cycle 3.
  - Latency is 3 cycles.
- Steady streaming sustains 1 word/cycle in and out with no bubbles.
- S_READY falls in the cycle after the push that makes ram_cnt = DEPTH. It rises in the cycle after the issue that frees a slot.
- Empty RAM with out_cnt = 0 gives M_VALID = 0. M_DATA holds its last value while M_VALID = 0.

## Configuration
- SYNC_FIFO_LEVEL_EN defined:
  - LEVEL port exists, with LEVEL = ram_cnt + rd_pend + out_cnt.
  - LEVEL is registered-consistent, i.e. it reflects state after the last edge.
  - LEVEL resets to 0.
- SYNC_FIFO_LEVEL_EN undefined: the LEVEL port and its logic are absent. All other behaviour is identical.

## Test plan
All scenarios use DWIDTH=8, AWIDTH=2 (DEPTH=4), with a behavioural RAM model.

- Reset: hold RST_N low 3 cycles, then release. Required: S_READY=1, M_VALID=0, M_DATA=0x00, RAM_ENA=RAM_ENB=0, LEVEL=0.
- Single word: push 0xA5 in cycle 0 with M_READY=0. Required: RAM_ADDRA=0 in cycle 0; RAM_ENB=1 with RAM_ADDRB=0 in cycle 1; M_VALID=1 with M_DATA=0xA5 from cycle 3 and held.
- Fill: M_READY=0, S_VALID=1 with data 0x01..0x08 offered continuously. Required:
  - exactly 6 words accepted (0x01..0x06);
  - S_READY=0 from cycle 6;
  - LEVEL=6.
  - Then with M_READY=1: 0x01..0x06 are output in order, then M_VALID=0.
- Streaming: 16 words 0x10..0x1F, S_VALID=M_READY=1. Required: outputs on consecutive cycles starting in cycle 3, pointers wrap 3→0 four times, no gaps.
- Backpressure: continuous input, M_READY toggling 1/0 each cycle, 20 words. Required: no loss or duplication, in-order output.
- Reset mid-operation: 3 words stored and a read in flight, then pull RST_N low for 1 cycle. Required:
  - M_VALID drops to 0 immediately;
  - after release, the FIFO is empty;
  - a new push of 0x5A is the first word out, at release+3 cycles.
